dl_rr_arb: RTL

DL_RR_ARB -- requirements
Module: dl_rr_arb

---
 rtl/dl_rr_arb.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dl_rr_arb.sv
// rtl/dl_rr_arb.sv - round-robin arbiter with registered output beat; packet locking under DL_RR_ARB_LOCK_EN
module dl_rr_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_BITS-1:0]          out_data,
    output logic [$clog2(NUM_REQ)-1:0]    out_id,
    input  logic                          out_ready
`ifdef DL_RR_ARB_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic                          out_last
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    // Requester index ofs places above base, wrapping NUM_REQ-1 -> 0.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int ofs);
        int sum;
        sum = int'(base) + ofs;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum[ID_W-1:0];
    endfunction

    logic [DATA_BITS-1:0] data_arr [NUM_REQ];
    logic [ID_W-1:0]      ptr;
    logic                 accept;
    logic                 gnt_found;
    logic [ID_W-1:0]      gnt_id;
    logic [ID_W-1:0]      cand;
    logic                 xfer;
    logic                 advance;
    logic                 locked;
    logic [ID_W-1:0]      lock_id;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_BITS +: DATA_BITS];
    end

    // The output register can take a new beat when empty or being drained this cycle.
    assign accept = !out_valid | out_ready;
    assign xfer   = rst_n & accept & gnt_found;

`ifdef DL_RR_ARB_LOCK_EN
    typedef enum logic {ARB_OPEN, ARB_LOCKED} lock_state_t;

    lock_state_t     state_q, state_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;

    assign locked  = (state_q == ARB_LOCKED);
    assign lock_id = lock_id_q;
    // The pointer only moves once a packet has closed.
    assign advance = req_last[gnt_id];

    // Lock state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARB_OPEN;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Open a lock on a non-last beat; release it when the owner sends its last beat.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        case (state_q)
            ARB_OPEN: begin
                if (xfer && !req_last[gnt_id]) begin
                    state_d   = ARB_LOCKED;
                    lock_id_d = gnt_id;
                end
            end
            ARB_LOCKED: begin
                if (xfer && req_last[gnt_id]) begin
                    state_d = ARB_OPEN;
                end
            end
            default: state_d = ARB_OPEN;
        endcase
    end
`else
    assign locked  = 1'b0;
    assign lock_id = '0;
    assign advance = 1'b1;
`endif

    // First valid requester at or above ptr, restricted to the lock owner while locked.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(ptr, k);
            if (!gnt_found && req_valid[cand] && (!locked || cand == lock_id)) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    // One-hot accept strobe for the winner only, suppressed in reset.
    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // Output beat register and priority pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= '0;
`ifdef DL_RR_ARB_LOCK_EN
            out_last  <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= data_arr[gnt_id];
            out_id    <= gnt_id;
`ifdef DL_RR_ARB_LOCK_EN
            out_last  <= req_last[gnt_id];
`endif
            if (advance) begin
                ptr <= wrap_add(gnt_id, 1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
